// File: rtl/ar_burst.sv
// ar_burst: memory address register with load, stride step and burst engine.
//
// Holds the current memory address on dout. In IDLE it can be loaded from
// BusOut/IOut, stepped up or down by STRIDE, or told to run a burst of
// BurstLen beats. During a burst the register presents each beat address to
// memory and advances by STRIDE every time memory accepts one.
//
// Handshake: MemReq is high for every cycle of BURST and dout is the address
// on offer. A beat completes on a rising Clk where MemReq and MemAck are both
// high. MemReq never drops before the burst ends, and dout only changes when
// a beat completes. There is no timeout.
//
// Ports:
//   Clk        in   rising-edge clock
//   Rst        in   asynchronous active-high reset
//   WEN        in   load enable (IDLE only)
//   selAR      in   load source: 0 = BusOut, 1 = IOut
//   BusOut     in   bus load value
//   IOut       in   instruction-field load value
//   Inc / Dec  in   step dout up / down by STRIDE (IDLE only)
//   BurstStart in   start a burst of BurstLen beats (IDLE only, BurstLen != 0)
//   BurstLen   in   burst length, sampled with BurstStart
//   MemAck     in   memory accepted the current beat address
//   dout       out  current address (registered)
//   MemReq     out  burst address valid
//   Busy       out  high in BURST and DONE
//   Done       out  one-cycle pulse after the last beat
//   Wrap       out  one-cycle pulse after a step or beat crossed 2^WIDTH
//   state_dbg  out  raw FSM state, for observation only
module ar_burst #(
  parameter int WIDTH   = 8,
  parameter int STRIDE  = 1,
  parameter int BURST_W = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               WEN,
  input  logic               selAR,
  input  logic [WIDTH-1:0]   BusOut,
  input  logic [WIDTH-1:0]   IOut,
  input  logic               Inc,
  input  logic               Dec,
  input  logic               BurstStart,
  input  logic [BURST_W-1:0] BurstLen,
  input  logic               MemAck,
  output logic [WIDTH-1:0]   dout,
  output logic               MemReq,
  output logic               Busy,
  output logic               Done,
  output logic               Wrap,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   STEP     = WIDTH'(STRIDE);
  localparam logic [BURST_W-1:0] ONE_BEAT = BURST_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dout_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               wrap_d;

  // One extra bit on the sum captures the carry out of the top address bit.
  logic [WIDTH:0]     sum_up;
  logic [WIDTH-1:0]   sum_dn;
  logic               borrow;

  assign sum_up = {1'b0, dout} + {1'b0, STEP};
  assign sum_dn = dout - STEP;
  assign borrow = (dout < STEP);

  always_comb begin
    state_d = state_q;
    dout_d  = dout;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Fixed priority; lower-priority commands in the same cycle are dropped.
        if (WEN) begin
          dout_d = selAR ? IOut : BusOut;
        end else if (Inc) begin
          dout_d = sum_up[WIDTH-1:0];
          wrap_d = sum_up[WIDTH];
        end else if (Dec) begin
          dout_d = sum_dn;
          wrap_d = borrow;
        end else if (BurstStart && (BurstLen != '0)) begin
          // First beat is the address already in dout.
          rem_d   = BurstLen;
          state_d = BURST;
        end
      end
      BURST: begin
        if (MemAck) begin
          dout_d = sum_up[WIDTH-1:0];
          wrap_d = sum_up[WIDTH];
          if (rem_q == ONE_BEAT) begin
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rem_d = rem_q - ONE_BEAT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      dout    <= '0;
      rem_q   <= '0;
      Wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      dout    <= dout_d;
      rem_q   <= rem_d;
      Wrap    <= wrap_d;
    end
  end

  // Flags decode straight from the state register, so they carry no
  // combinational path from the inputs.
  assign MemReq    = (state_q == BURST);
  assign Done      = (state_q == DONE);
  assign Busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ar_burst.sv
module tb_ar_burst;

  localparam int WIDTH   = 8;
  localparam int STRIDE  = 1;
  localparam int BURST_W = 4;
  localparam int MOD     = 1 << WIDTH;
  localparam int N_RAND  = 1500;

  // ---------------- clock / reset / DUT ----------------
  logic               Clk = 1'b0;
  logic               Rst;
  logic               WEN, selAR, Inc, Dec, BurstStart, MemAck;
  logic [WIDTH-1:0]   BusOut, IOut;
  logic [BURST_W-1:0] BurstLen;
  logic [WIDTH-1:0]   dout;
  logic               MemReq, Busy, Done, Wrap;
  logic [1:0]         state_dbg;

  always #5 Clk = ~Clk;

  ar_burst #(.WIDTH(WIDTH), .STRIDE(STRIDE), .BURST_W(BURST_W)) dut (
    .Clk(Clk), .Rst(Rst), .WEN(WEN), .selAR(selAR), .BusOut(BusOut),
    .IOut(IOut), .Inc(Inc), .Dec(Dec), .BurstStart(BurstStart),
    .BurstLen(BurstLen), .MemAck(MemAck), .dout(dout), .MemReq(MemReq),
    .Busy(Busy), .Done(Done), .Wrap(Wrap), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH+3:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    WEN = 0; selAR = 0; BusOut = '0; IOut = '0; Inc = 0; Dec = 0;
    BurstStart = 0; BurstLen = '0; MemAck = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             wen, sel;
    logic [WIDTH-1:0] bus, iout;
    logic             inc, dec, bs;
    logic [3:0]       blen;
    logic             ack;
    logic [WIDTH-1:0] e_dout;
    logic             e_req, e_busy, e_done, e_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wen, input logic sel, input logic [7:0] bus,
                     input logic [7:0] iout, input logic inc, input logic dec,
                     input logic bs, input logic [3:0] blen, input logic ack,
                     input logic [7:0] e_dout, input logic e_req,
                     input logic e_busy, input logic e_done, input logic e_wrap);
    vec_t v;
    v.wen = wen; v.sel = sel; v.bus = bus; v.iout = iout; v.inc = inc;
    v.dec = dec; v.bs = bs; v.blen = blen; v.ack = ack; v.e_dout = e_dout;
    v.e_req = e_req; v.e_busy = e_busy; v.e_done = e_done; v.e_wrap = e_wrap;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Tracks the address as an integer and the burst as "beats still owed";
  // done_cycle marks the single completion cycle after the last beat.
  int m_dout = 0;
  int m_rem  = 0;
  bit m_done = 0;

  task automatic model_step();
    bit w;
    w = 0;
    if (m_done) begin
      m_done = 0;
    end else if (m_rem > 0) begin
      if (MemAck) begin
        w      = (m_dout + STRIDE) >= MOD;
        m_dout = (m_dout + STRIDE) % MOD;
        m_rem  = m_rem - 1;
        if (m_rem == 0) m_done = 1;
      end
    end else if (WEN) begin
      m_dout = selAR ? int'(IOut) : int'(BusOut);
    end else if (Inc) begin
      w      = (m_dout + STRIDE) >= MOD;
      m_dout = (m_dout + STRIDE) % MOD;
    end else if (Dec) begin
      w      = m_dout < STRIDE;
      m_dout = (m_dout - STRIDE + MOD) % MOD;
    end else if (BurstStart && BurstLen != 0) begin
      m_rem = int'(BurstLen);
    end
    exp_q.push_back({WIDTH'(m_dout), m_rem > 0, (m_rem > 0) || m_done, m_done, w});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [WIDTH+3:0] e, a;
    idle_inputs();
    Rst = 1;
    #12;
    chk("reset dout", dout, 0);
    chk("reset MemReq", MemReq, 0);
    chk("reset Busy", Busy, 0);
    chk("reset Done", Done, 0);
    chk("reset Wrap", Wrap, 0);
    Rst = 0;

    //   wen sel bus    iout   inc dec bs blen ack | dout   req busy done wrap
    add(1, 0, 8'hAA, 8'h00, 0, 0, 0, 0, 0,  8'hAA, 0, 0, 0, 0);
    add(1, 1, 8'h00, 8'h88, 0, 0, 0, 0, 0,  8'h88, 0, 0, 0, 0);
    add(0, 0, 8'h12, 8'h34, 0, 0, 0, 0, 0,  8'h88, 0, 0, 0, 0);
    add(0, 1, 8'h77, 8'h66, 0, 0, 0, 0, 1,  8'h88, 0, 0, 0, 0);
    add(1, 0, 8'h10, 8'h00, 0, 0, 0, 0, 0,  8'h10, 0, 0, 0, 0);
    add(1, 0, 8'h55, 8'h00, 1, 0, 1, 3, 0,  8'h55, 0, 0, 0, 0);
    add(1, 0, 8'hFF, 8'h00, 0, 0, 0, 0, 0,  8'hFF, 0, 0, 0, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0,  8'h00, 0, 0, 0, 1);
    add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0,  8'hFF, 0, 0, 0, 1);
    add(1, 0, 8'h20, 8'h00, 0, 0, 0, 0, 0,  8'h20, 0, 0, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 1, 3, 0,  8'h20, 1, 1, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1,  8'h21, 1, 1, 0, 0);
    add(1, 0, 8'h99, 8'h00, 1, 0, 1, 7, 0,  8'h21, 1, 1, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1,  8'h22, 1, 1, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1,  8'h23, 0, 1, 1, 0);
    add(1, 0, 8'h99, 8'h00, 0, 1, 0, 0, 0,  8'h23, 0, 0, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1,  8'h23, 0, 0, 0, 0);
    add(1, 0, 8'hFE, 8'h00, 0, 0, 0, 0, 0,  8'hFE, 0, 0, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 1, 4, 0,  8'hFE, 1, 1, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1,  8'hFF, 1, 1, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1,  8'h00, 1, 1, 0, 1);
    add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1,  8'h01, 1, 1, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1,  8'h02, 0, 1, 1, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0,  8'h02, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      WEN = vecs[i].wen; selAR = vecs[i].sel; BusOut = vecs[i].bus;
      IOut = vecs[i].iout; Inc = vecs[i].inc; Dec = vecs[i].dec;
      BurstStart = vecs[i].bs; BurstLen = vecs[i].blen; MemAck = vecs[i].ack;
      tick();
      chk($sformatf("row%0d dout", i), dout, vecs[i].e_dout);
      chk($sformatf("row%0d MemReq", i), MemReq, vecs[i].e_req);
      chk($sformatf("row%0d Busy", i), Busy, vecs[i].e_busy);
      chk($sformatf("row%0d Done", i), Done, vecs[i].e_done);
      chk($sformatf("row%0d Wrap", i), Wrap, vecs[i].e_wrap);
    end

    // Asynchronous reset between edges clears the register at once.
    idle_inputs();
    WEN = 1; BusOut = 8'hAA;
    tick();
    chk("preload dout", dout, 8'hAA);
    idle_inputs();
    #3 Rst = 1;
    #1;
    chk("async rst dout", dout, 0);
    chk("async rst Busy", Busy, 0);
    #2 Rst = 0;
    tick();

    // Reset in the middle of a 5-beat burst, after two beats.
    WEN = 1; BusOut = 8'h40;
    tick();
    WEN = 0; BurstStart = 1; BurstLen = 4'd5;
    tick();
    chk("burst5 MemReq", MemReq, 1);
    BurstStart = 0; BurstLen = '0; MemAck = 1;
    tick();
    tick();
    chk("burst5 two beats", dout, 8'h42);
    MemAck = 0;
    #3 Rst = 1;
    #1;
    chk("midburst rst dout", dout, 0);
    chk("midburst rst MemReq", MemReq, 0);
    chk("midburst rst Busy", Busy, 0);
    chk("midburst rst Done", Done, 0);
    tick();
    chk("held rst Done", Done, 0);
    Rst = 0;
    WEN = 1; BusOut = 8'h3C; MemAck = 1;
    tick();
    chk("load after rst dout", dout, 8'h3C);
    chk("load after rst Busy", Busy, 0);
    chk("load after rst Done", Done, 0);

    // Randomized run against the reference model.
    idle_inputs();
    Rst = 1;
    tick();
    Rst = 0;
    m_dout = 0; m_rem = 0; m_done = 0;
    for (int c = 0; c < N_RAND; c++) begin
      WEN        = ($urandom_range(0, 9) == 0);
      selAR      = 1'($urandom_range(0, 1));
      BusOut     = WIDTH'($urandom_range(0, MOD - 1));
      IOut       = WIDTH'($urandom_range(0, MOD - 1));
      Inc        = ($urandom_range(0, 2) == 0);
      Dec        = ($urandom_range(0, 2) == 0);
      BurstStart = ($urandom_range(0, 3) == 0);
      BurstLen   = BURST_W'($urandom_range(0, (1 << BURST_W) - 1));
      MemAck     = 1'($urandom_range(0, 1));
      model_step();
      tick();
      e = exp_q.pop_front();
      a = {dout, MemReq, Busy, Done, Wrap};
      chk($sformatf("rand cycle %0d {dout,req,busy,done,wrap}", c), a, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
